// File: rtl/pipe_stage_buf_pkg.sv
// pipe_pkg: shared widths, helpers and per-stage payload layouts for pipeline latches.
package pipe_pkg;
    localparam int PIPE_W_EXMEM = 128;
    localparam int PIPE_W_IDEX  = 128;
    typedef logic [31:0] pipe_cnt_t;
    function automatic int pipe_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction
    function automatic int pipe_ptr_w(input int depth);
        return depth > 1 ? $clog2(depth) : 1;
    endfunction
    typedef struct packed {
        logic [23:0] pad;
        logic [31:0] pc;
        logic [31:0] alu_out;
        logic [31:0] store_data;
        logic [4:0]  rd;
        logic        reg_wen;
        logic        dWEN;
        logic        dREN;
    } exmem_pl_t;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
    } idex_pl_t;
endpackage

// File: rtl/pipe_stage_buf_if.sv
// pipe_stage_buf_if: handshake, control and status bundle of one pipeline stage buffer.
interface pipe_stage_buf_if
    import pipe_pkg::*;
#(
    parameter int WIDTH = 128,
    parameter int DEPTH = 2
)();
    logic                         flush;
    logic                         clr_req;
    logic                         in_valid;
    logic                         in_ready;
    logic [WIDTH-1:0]             in_data;
    logic                         out_valid;
    logic                         out_ready;
    logic [WIDTH-1:0]             out_data;
    logic [pipe_cnt_w(DEPTH)-1:0] count;
    pipe_cnt_t                    stall_cnt;
    modport master (
        output flush, clr_req, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count, stall_cnt
    );
    modport slave (
        input  flush, clr_req, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count, stall_cnt
    );
endinterface

// File: rtl/pipe_stage_buf_mem.sv
// pipe_buf_mem: DEPTH x WIDTH entry array with one write port and a masked clear on the read slot.
module pipe_buf_mem #(
    parameter int               WIDTH    = 128,
    parameter int               DEPTH    = 2,
    parameter int               PW       = 1,
    parameter logic [WIDTH-1:0] CLR_MASK = '0
) (
    input  logic             i_clk,
    input  logic             i_wr_en,
    input  logic [PW-1:0]    i_wr_ptr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_clr_en,
    input  logic [PW-1:0]    i_rd_ptr,
    output logic [WIDTH-1:0] o_rd_data
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        always_ff @(posedge i_clk) begin
            if (i_wr_en && i_wr_ptr == PW'(g))
                r_mem[g] <= i_wr_data;
            else if (i_clr_en && i_rd_ptr == PW'(g))
                r_mem[g] <= r_mem[g] & ~CLR_MASK;
        end
    end
    assign o_rd_data = r_mem[i_rd_ptr];
endmodule

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: elastic DEPTH-entry pipeline register with flush and masked head clear.
// Optional stall counter enabled by PIPE_BUF_PERF_EN.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = 128,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] CLR_MASK  = '0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input logic              CLK,
    input logic              RST,
    pipe_stage_buf_if.slave  bus
);
    localparam int CW = pipe_cnt_w(DEPTH);
    localparam int PW = pipe_ptr_w(DEPTH);
    logic [CW-1:0]    r_count;
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic             w_push;
    logic             w_pop;
    logic             w_clr;
    logic [WIDTH-1:0] w_head;
    assign bus.in_ready  = r_count != CW'(DEPTH);
    assign bus.out_valid = r_count != '0;
    assign bus.out_data  = bus.out_valid ? w_head : RESET_VAL;
    assign bus.count     = r_count;
    assign w_push = bus.in_valid & bus.in_ready & ~bus.flush;
    assign w_pop  = bus.out_valid & bus.out_ready;
    // A popped head leaves anyway, so clearing it would be wasted work.
    assign w_clr  = bus.clr_req & bus.out_valid & ~w_pop & ~bus.flush;
    pipe_buf_mem #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .PW(PW), .CLR_MASK(CLR_MASK)
    ) u_mem (
        .i_clk    (CLK),
        .i_wr_en  (w_push),
        .i_wr_ptr (r_wr_ptr),
        .i_wr_data(bus.in_data),
        .i_clr_en (w_clr),
        .i_rd_ptr (r_rd_ptr),
        .o_rd_data(w_head)
    );
    always_ff @(posedge CLK or posedge RST) begin
        if (RST || bus.flush) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            if (w_push)
                r_wr_ptr <= r_wr_ptr == PW'(DEPTH - 1) ? '0 : r_wr_ptr + PW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr == PW'(DEPTH - 1) ? '0 : r_rd_ptr + PW'(1);
        end
    end
`ifdef PIPE_BUF_PERF_EN
    pipe_cnt_t r_stall_cnt;
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            r_stall_cnt <= '0;
        else if (bus.out_valid && !bus.out_ready && r_stall_cnt != '1)
            r_stall_cnt <= r_stall_cnt + 32'd1;
    end
    assign bus.stall_cnt = r_stall_cnt;
`else
    assign bus.stall_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: directed vector table on a DEPTH=2 buffer plus reset, perf and DEPTH=3 wrap sequences.
module tb_pipe_stage_buf;
    import pipe_pkg::*;
    typedef struct {
        logic       fl, cl, iv;
        logic [7:0] d;
        logic       ordy;
        logic       ov;
        logic [7:0] od;
        logic       ir;
        logic [1:0] cnt;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_vec = 0;
    int n_bad = 0;
    vec_t tbl[$];
    logic [7:0] q[$];
    always #5 clk = ~clk;
    pipe_stage_buf_if #(.WIDTH(8), .DEPTH(2)) d2();
    pipe_stage_buf_if #(.WIDTH(8), .DEPTH(3)) d3();
    pipe_stage_buf #(.WIDTH(8), .DEPTH(2), .CLR_MASK(8'h03), .RESET_VAL(8'h00)) u_d2 (
        .CLK(clk), .RST(rst), .bus(d2.slave)
    );
    pipe_stage_buf #(.WIDTH(8), .DEPTH(3), .CLR_MASK(8'h03), .RESET_VAL(8'h00)) u_d3 (
        .CLK(clk), .RST(rst), .bus(d3.slave)
    );
    function automatic vec_t mk(logic fl, cl, iv, logic [7:0] d, logic ordy,
                                logic ov, logic [7:0] od, logic ir, logic [1:0] cnt);
        vec_t t;
        t.fl = fl; t.cl = cl; t.iv = iv; t.d = d; t.ordy = ordy;
        t.ov = ov; t.od = od; t.ir = ir; t.cnt = cnt;
        return t;
    endfunction
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic drv2(input logic fl, cl, iv, input logic [7:0] d, input logic ordy);
        d2.flush = fl; d2.clr_req = cl; d2.in_valid = iv; d2.in_data = d; d2.out_ready = ordy;
    endtask
    function automatic logic [31:0] st2();
        return {20'b0, d2.out_valid, d2.out_data, d2.in_ready, d2.count};
    endfunction
    initial begin
        logic [31:0] exp_stall;
        int sent;
        drv2(0, 0, 0, 8'h00, 0);
        d3.flush = 0; d3.clr_req = 0; d3.in_valid = 0; d3.in_data = 0; d3.out_ready = 0;
        // fl cl iv data ordy | ov od ir cnt
        tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 0));
        tbl.push_back(mk(0, 0, 1, 8'hA1, 0, 0, 8'h00, 1, 0));
        tbl.push_back(mk(0, 0, 1, 8'hB2, 0, 1, 8'hA1, 1, 1));
        tbl.push_back(mk(0, 0, 1, 8'hC3, 0, 1, 8'hA1, 0, 2));
        tbl.push_back(mk(0, 0, 0, 8'h00, 1, 1, 8'hA1, 0, 2));
        tbl.push_back(mk(0, 0, 0, 8'h00, 1, 1, 8'hB2, 1, 1));
        tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 0));
        for (int k = 1; k <= 10; k++)
            tbl.push_back(k == 1 ? mk(0, 0, 1, 8'(k), 1, 0, 8'h00, 1, 0)
                                 : mk(0, 0, 1, 8'(k), 1, 1, 8'(k - 1), 1, 1));
        tbl.push_back(mk(0, 0, 0, 8'h00, 1, 1, 8'h0A, 1, 1));
        tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 0));
        tbl.push_back(mk(0, 0, 1, 8'hFF, 0, 0, 8'h00, 1, 0));
        tbl.push_back(mk(0, 1, 0, 8'h00, 0, 1, 8'hFF, 1, 1));
        tbl.push_back(mk(0, 0, 0, 8'h00, 0, 1, 8'hFC, 1, 1));
        tbl.push_back(mk(0, 0, 0, 8'h00, 1, 1, 8'hFC, 1, 1));
        tbl.push_back(mk(0, 0, 1, 8'hFF, 0, 0, 8'h00, 1, 0));
        tbl.push_back(mk(0, 1, 0, 8'h00, 1, 1, 8'hFF, 1, 1));
        tbl.push_back(mk(0, 0, 1, 8'hFF, 0, 0, 8'h00, 1, 0));
        tbl.push_back(mk(0, 1, 1, 8'h0F, 0, 1, 8'hFF, 1, 1));
        tbl.push_back(mk(0, 0, 0, 8'h00, 1, 1, 8'hFC, 0, 2));
        tbl.push_back(mk(0, 0, 0, 8'h00, 1, 1, 8'h0F, 1, 1));
        tbl.push_back(mk(0, 1, 0, 8'h00, 0, 0, 8'h00, 1, 0));
        tbl.push_back(mk(0, 0, 1, 8'h11, 0, 0, 8'h00, 1, 0));
        tbl.push_back(mk(0, 0, 1, 8'h22, 0, 1, 8'h11, 1, 1));
        tbl.push_back(mk(1, 0, 1, 8'h55, 0, 1, 8'h11, 0, 2));
        tbl.push_back(mk(1, 0, 1, 8'h55, 0, 0, 8'h00, 1, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 0));
        tbl.push_back(mk(0, 0, 1, 8'h33, 0, 0, 8'h00, 1, 0));
        tbl.push_back(mk(1, 0, 1, 8'h55, 1, 1, 8'h33, 1, 1));
        tbl.push_back(mk(0, 0, 0, 8'h00, 1, 0, 8'h00, 1, 0));
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        foreach (tbl[i]) begin
            drv2(tbl[i].fl, tbl[i].cl, tbl[i].iv, tbl[i].d, tbl[i].ordy);
            #1;
            chk($sformatf("vec%0d", i), st2(), {20'b0, tbl[i].ov, tbl[i].od, tbl[i].ir, tbl[i].cnt});
            @(negedge clk);
        end
        // Asynchronous reset while full must clear outputs without waiting for an edge.
        drv2(0, 0, 1, 8'hA1, 0);
        @(negedge clk);
        d2.in_data = 8'hB2;
        @(negedge clk);
        drv2(0, 0, 0, 8'h00, 0);
        #1;
        chk("prefill_cnt", 32'(d2.count), 32'd2);
        @(posedge clk);
        #2 rst = 1;
        #1 chk("async_rst", st2(), {20'b0, 1'b0, 8'h00, 1'b1, 2'd0});
        @(negedge clk);
        rst = 0;
`ifdef PIPE_BUF_PERF_EN
        exp_stall = 32'd5;
`else
        exp_stall = 32'd0;
`endif
        drv2(0, 0, 1, 8'h5A, 0);
        @(negedge clk);
        d2.in_valid = 0;
        repeat (5) @(negedge clk);
        chk("stall_cnt", d2.stall_cnt, exp_stall);
        drv2(1, 0, 0, 8'h00, 1);
        @(negedge clk);
        drv2(0, 0, 0, 8'h00, 0);
        #1;
        chk("stall_after_flush", d2.stall_cnt, exp_stall);
        chk("flush_empty", 32'(d2.out_valid), 32'd0);
        sent = 0;
        for (int c = 0; c < 60 && (sent < 7 || q.size() > 0); c++) begin
            d3.in_valid  = (c % 3 != 2) && sent < 7;
            d3.in_data   = 8'h40 + 8'(sent);
            d3.out_ready = (c % 2 == 1);
            #1;
            chk($sformatf("d3_cnt%0d", c), 32'(d3.count), 32'(q.size()));
            chk($sformatf("d3_ir%0d", c), 32'(d3.in_ready), 32'(q.size() != 3));
            if (d3.out_valid && d3.out_ready && q.size() > 0) begin
                chk($sformatf("d3_data%0d", c), 32'(d3.out_data), 32'(q[0]));
                q.pop_front();
            end
            if (d3.in_valid && d3.in_ready) begin
                q.push_back(d3.in_data);
                sent++;
            end
            @(negedge clk);
        end
        d3.in_valid = 0;
        d3.out_ready = 0;
        chk("d3_done", {16'(sent), 16'(q.size())}, {16'd7, 16'd0});
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
